// File: rtl/eep_arb_pkg.sv
// Shared definitions for the EEPROM request arbiter: FSM states, source
// indices, operation encoding and the fixed-priority pick helper.
package eep_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_KEY  = 2'd1;
  localparam logic [1:0] SRC_PS2  = 2'd2;
  localparam logic [1:0] SRC_VO   = 2'd3;

  localparam logic OP_SAVE  = 1'b1;
  localparam logic OP_FETCH = 1'b0;

  localparam int ADDR_W = 5;
  localparam int TMO_W  = 25;
  localparam int GAP_W  = 18;

  // pend bit0 = key, bit1 = ps2, bit2 = voice; voice outranks ps2 outranks key.
  function automatic logic [1:0] pick_src(input logic [2:0] pend);
    logic [1:0] src;
    src = SRC_NONE;
    if (pend[2])      src = SRC_VO;
    else if (pend[1]) src = SRC_PS2;
    else if (pend[0]) src = SRC_KEY;
    return src;
  endfunction

  function automatic logic [2:0] src_onehot(input logic [1:0] src);
    logic [2:0] oh;
    oh = 3'b000;
    case (src)
      SRC_KEY: oh = 3'b001;
      SRC_PS2: oh = 3'b010;
      SRC_VO:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/eep_req_slot.sv
// One pending request slot: a pending flag plus the op/addr of the latest
// request. A set in the same cycle as a clear wins, so no request is lost.
module eep_req_slot
  import eep_arb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_set,
  input  logic              i_op,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_clr,
  output logic              o_pend,
  output logic              o_op,
  output logic [ADDR_W-1:0] o_addr
);

  logic              r_pend;
  logic              r_op;
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend <= 1'b0;
      r_op   <= OP_FETCH;
      r_addr <= '0;
    end else if (i_set) begin
      r_pend <= 1'b1;
      r_op   <= i_op;
      r_addr <= i_addr;
    end else if (i_clr) begin
      r_pend <= 1'b0;
    end
  end

  assign o_pend = r_pend;
  assign o_op   = r_op;
  assign o_addr = r_addr;

endmodule

// File: rtl/eep_req_arbiter.sv
// Arbitrates keypad, PS/2 and voice save/fetch requests onto a single EEPROM
// engine with fixed priority, completion timeout and a post-operation gap.
//
// Handshake: each *_req is a one-cycle pulse with op/addr valid in that cycle
// (no ready; a later pulse overwrites an ungranted one). eep_wr/eep_rd are
// one-cycle strobes, eep_done a one-cycle pulse honoured only in WAIT, and
// ack/nak one-cycle pulses on the completing source's bit.
module eep_req_arbiter
  import eep_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 24_000_000,
  parameter int unsigned GAP_CYC     = 240_000
) (
  input  logic       clk_24m,
  input  logic       rst_n,
  input  logic       key_req,
  input  logic       ps2_req,
  input  logic       vo_req,
  input  logic       key_op,
  input  logic       ps2_op,
  input  logic       vo_op,
  input  logic [4:0] key_addr,
  input  logic [4:0] ps2_addr,
  input  logic [4:0] vo_addr,
  input  logic       alarm,
  input  logic       eep_done,
  output logic       eep_wr,
  output logic       eep_rd,
  output logic [4:0] eep_addr,
  output logic [1:0] cur_src,
  output logic [2:0] ack,
  output logic [2:0] nak,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

  state_t            r_state;
  logic [1:0]        r_src;
  logic              r_op;
  logic [4:0]        r_addr;
  logic              r_eep_wr;
  logic              r_eep_rd;
  logic [2:0]        r_ack;
  logic [2:0]        r_nak;
  logic [TMO_W-1:0]  r_tmo;
  logic [GAP_W-1:0]  r_gap;

  logic              w_key_pend, w_ps2_pend, w_vo_pend;
  logic              w_key_op, w_ps2_op, w_vo_op;
  logic [4:0]        w_key_addr, w_ps2_addr, w_vo_addr;
  logic [2:0]        w_pend;
  logic [1:0]        w_win;
  logic              w_grant;
  logic              w_sel_op;
  logic [4:0]        w_sel_addr;

  eep_req_slot u_key_slot (
    .i_clk   (clk_24m),
    .i_rst_n (rst_n),
    .i_set   (key_req),
    .i_op    (key_op),
    .i_addr  (key_addr),
    .i_clr   (w_grant && (w_win == SRC_KEY)),
    .o_pend  (w_key_pend),
    .o_op    (w_key_op),
    .o_addr  (w_key_addr)
  );

  eep_req_slot u_ps2_slot (
    .i_clk   (clk_24m),
    .i_rst_n (rst_n),
    .i_set   (ps2_req),
    .i_op    (ps2_op),
    .i_addr  (ps2_addr),
    .i_clr   (w_grant && (w_win == SRC_PS2)),
    .o_pend  (w_ps2_pend),
    .o_op    (w_ps2_op),
    .o_addr  (w_ps2_addr)
  );

  eep_req_slot u_vo_slot (
    .i_clk   (clk_24m),
    .i_rst_n (rst_n),
    .i_set   (vo_req),
    .i_op    (vo_op),
    .i_addr  (vo_addr),
    .i_clr   (w_grant && (w_win == SRC_VO)),
    .o_pend  (w_vo_pend),
    .o_op    (w_vo_op),
    .o_addr  (w_vo_addr)
  );

  assign w_pend  = {w_vo_pend, w_ps2_pend, w_key_pend};
  assign w_win   = pick_src(w_pend);
  assign w_grant = (r_state == ST_IDLE) && (|w_pend) && !alarm;

  always_comb begin
    w_sel_op   = w_key_op;
    w_sel_addr = w_key_addr;
    case (w_win)
      SRC_PS2: begin
        w_sel_op   = w_ps2_op;
        w_sel_addr = w_ps2_addr;
      end
      SRC_VO: begin
        w_sel_op   = w_vo_op;
        w_sel_addr = w_vo_addr;
      end
      default: begin
        w_sel_op   = w_key_op;
        w_sel_addr = w_key_addr;
      end
    endcase
  end

  // Strobes are registered out of ISSUE, so they coincide with WAIT entry and
  // the timeout window starts on the strobe cycle itself.
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_src    <= SRC_NONE;
      r_op     <= OP_FETCH;
      r_addr   <= '0;
      r_eep_wr <= 1'b0;
      r_eep_rd <= 1'b0;
      r_ack    <= 3'b000;
      r_nak    <= 3'b000;
      r_tmo    <= '0;
      r_gap    <= '0;
    end else begin
      r_eep_wr <= 1'b0;
      r_eep_rd <= 1'b0;
      r_ack    <= 3'b000;
      r_nak    <= 3'b000;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state <= ST_ISSUE;
            r_src   <= w_win;
            r_op    <= w_sel_op;
            r_addr  <= w_sel_addr;
          end
        end
        ST_ISSUE: begin
          r_state  <= ST_WAIT;
          r_eep_wr <= (r_op == OP_SAVE);
          r_eep_rd <= (r_op == OP_FETCH);
          r_tmo    <= TMO_LOAD;
        end
        ST_WAIT: begin
          if (eep_done) begin
            r_state <= ST_GAP;
            r_ack   <= src_onehot(r_src);
            r_gap   <= GAP_LOAD;
          end else if (r_tmo == '0) begin
            r_state <= ST_GAP;
            r_nak   <= src_onehot(r_src);
            r_gap   <= GAP_LOAD;
          end else begin
            r_tmo <= r_tmo - 1'b1;
          end
        end
        ST_GAP: begin
          if (r_gap == '0) begin
            r_state <= ST_IDLE;
            r_src   <= SRC_NONE;
          end else begin
            r_gap <= r_gap - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign eep_wr    = r_eep_wr;
  assign eep_rd    = r_eep_rd;
  assign eep_addr  = r_addr;
  assign cur_src   = r_src;
  assign ack       = r_ack;
  assign nak       = r_nak;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: doc/eep_req_arbiter.md
EEP_REQ_ARBITER -- requirements
Module: eep_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 24_000_000, max cycles from issue to eep_done (1 s at 24 MHz).
REQ-002 SHALL have parameter GAP_CYC, default 240_000, idle gap after each completed or failed operation (10 ms EEPROM write cycle).
REQ-003 SHALL have port clk_24m, in, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, in, 1, asynchronous active-low reset.
REQ-005 SHALL have ports key_req/ps2_req/vo_req, in, 1 each, one-cycle request pulses from keypad, PS/2 and voice sources.
REQ-006 SHALL have ports key_op/ps2_op/vo_op, in, 1 each, op sampled with req: 1 = save (write), 0 = fetch (read).
REQ-007 SHALL have ports key_addr/ps2_addr/vo_addr, in, 5 each, slot address sampled with req.
REQ-008 SHALL have port alarm, in, 1, level; while high, no new grant is issued.
REQ-009 SHALL have port eep_done, in, 1, one-cycle completion pulse from EEPROM engine.
REQ-010 SHALL have ports eep_wr and eep_rd, out, 1 each, one-cycle save/fetch strobes to EEPROM engine.
REQ-011 SHALL have port eep_addr, out, 5, address of current operation, stable from strobe until the FSM leaves WAIT.
REQ-012 SHALL have port cur_src, out, 2, granted source: 0 none, 1 key, 2 ps2, 3 voice.
REQ-013 SHALL have ports ack and nak, out, 3 each, one-cycle per-source pulses on completion and timeout; bit0 key, bit1 ps2, bit2 voice.
REQ-014 SHALL have port busy, out, 1, high in every state other than IDLE.

Function
REQ-015 Each source SHALL have a pending slot: req pulse sets pending and overwrites stored op/addr; the latest request wins.
REQ-016 A new req on a source in the same cycle its pending is cleared by grant SHALL leave pending set with the new op/addr.
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, GAP.
REQ-018 IDLE->ISSUE SHALL occur when any pending is set and alarm=0; otherwise the FSM stays in IDLE.
REQ-019 Grant priority SHALL be fixed: voice > ps2 > key.
REQ-020 On IDLE->ISSUE the FSM SHALL latch the winner's op/addr into eep_addr and cur_src, and clear that source's pending.
REQ-021 ISSUE SHALL last exactly one cycle, asserting eep_wr (op=1) or eep_rd (op=0), never both, then go to WAIT.
REQ-022 Latency: a req sampled at edge N with FSM idle and no higher pending SHALL produce a strobe in the cycle after edge N+2.
REQ-023 WAIT SHALL go to GAP on eep_done and pulse ack[src] in the same transition cycle.
REQ-024 WAIT SHALL go to GAP after TIMEOUT_CYC cycles without eep_done and pulse nak[src]; if eep_done and timeout coincide, done wins.
REQ-025 eep_done outside WAIT SHALL be ignored.
REQ-026 GAP SHALL count GAP_CYC cycles, then go to IDLE with cur_src=0.
REQ-027 alarm rising during ISSUE, WAIT or GAP SHALL NOT abort the operation; pending requests are held until alarm falls.
REQ-028 The timeout counter SHALL be 25 bits and the gap counter 18 bits, both reloaded on state entry, with no wrap.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, clear all pending, and drive eep_wr, eep_rd, ack, nak, busy to 0 and eep_addr, cur_src to 0.
REQ-030 Reset mid-WAIT SHALL drop the operation silently; no ack or nak is issued.

Structure
REQ-031 Package eep_arb_pkg SHALL hold the state enum, source index constants (SRC_NONE/KEY/PS2/VO), and op encoding (OP_SAVE=1, OP_FETCH=0).
REQ-032 Sub-module eep_req_slot (pending bit plus op/addr register, set/clear with set priority) SHALL be instantiated three times.

Verification
REQ-033 key_req with op=1, addr=5; eep_done 10 cycles after strobe -> eep_wr one cycle, eep_addr=5, cur_src=1, ack=3'b001, busy low after GAP_CYC.
REQ-034 key_req, ps2_req, vo_req in the same cycle -> served in order voice, ps2, key; each strobe separated by at least GAP_CYC.
REQ-035 ps2_req addr=3, then ps2_req addr=9 before grant -> a single eep_rd with eep_addr=9.
REQ-036 vo_req, no eep_done -> nak=3'b100 exactly TIMEOUT_CYC cycles after strobe; eep_done 2 cycles later is ignored.
REQ-037 alarm high, then key_req -> no strobe while alarm is high; strobe 2 cycles after alarm falls.
REQ-038 rst_n low during WAIT -> outputs zero asynchronously; no ack or nak; a new request after release is served normally.
